io_section_loader: RTL and testbench

- Parametrised successor to the UART IO top: consumes the decoded UART byte stream, assembles words of WORD_BYTES bytes, and dispatches length-prefixed program sections to NUM_SECT memory regions with per-section base addresses.
- After the last section it switches to run mode. Further words are buffered in an input FIFO for the core's input instruction.
- Sits between the UART receiver and the instruction/data-memory write ports and the core input path.
- Drives io_stall until loading completes.

---
 rtl/io_section_loader.sv | 113 +++++++++++
 tb/tb_io_section_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_section_loader.sv
// io_section_loader: assembles UART bytes into words, loads length-prefixed sections, then feeds a run-mode input FIFO
module io_section_loader #(
  parameter int WORD_BYTES = 4,
  parameter int NUM_SECT = 2,
  parameter int ADDR_W = 32,
  parameter logic [NUM_SECT*ADDR_W-1:0] SECT_BASE = {32'h10000, 32'h0},
  parameter int FIFO_DEPTH = 8,
  localparam int DW = 8*WORD_BYTES,
  localparam int SW = NUM_SECT > 1 ? $clog2(NUM_SECT) : 1,
  localparam int CW = $clog2(FIFO_DEPTH)+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [SW-1:0]     wr_sect,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              io_stall,
  output logic              load_done,
  output logic [DW-1:0]     in_data,
  output logic              in_valid,
  input  logic              in_pop,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow
);
  localparam int AW = DW > 32 ? DW : 32;
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {LEN, DATA, RUN} state_t;
  state_t state, state_n;
  logic [2:0] bcnt;
  logic [AW-1:0] asm_q, asm_nx;
  logic [31:0] n_q, widx;
  logic [SW-1:0] sidx;
  logic [ADDR_W-1:0] base, off;
  logic [PW-1:0] rptr, wptr;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic done_word, last_sect, sect_end, data_word, run_word, load_wr, wv_n, push, pop, full;
  always_comb begin
    asm_nx = asm_q;
    for (int k = 0; k < AW/8; k++)
      if (bcnt == 3'(k)) asm_nx[8*k +: 8] = rx_data;
  end
  always_comb begin
    base = '0;
    for (int s = 0; s < NUM_SECT; s++)
      if (sidx == SW'(s)) base = SECT_BASE[s*ADDR_W +: ADDR_W];
  end
  // The length prefix is always 4 bytes, whatever the word size
  assign done_word = rx_valid && bcnt == (state == LEN ? 3'd3 : 3'(WORD_BYTES-1));
  assign last_sect = sidx == SW'(NUM_SECT-1);
  assign sect_end = state == LEN ? asm_nx[31:0] == 32'd0 : widx + 32'd1 == n_q;
  assign data_word = done_word && state == DATA;
  assign run_word = done_word && state == RUN;
  assign load_wr = data_word && (!wr_valid || wr_ready);
  assign wv_n = load_wr || (wr_valid && !wr_ready);
  assign off = ADDR_W'(widx) * ADDR_W'(WORD_BYTES);
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign pop = in_pop && fifo_count != '0;
  assign push = run_word && (!full || pop);
  assign in_valid = fifo_count != '0;
  assign in_data = in_valid ? mem[rptr] : '0;
  assign io_stall = ~load_done;
  always_comb begin
    state_n = state;
    if (done_word && state != RUN) state_n = sect_end ? (last_sect ? RUN : LEN) : DATA;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LEN;
      bcnt <= '0;
      asm_q <= '0;
      n_q <= '0;
      widx <= '0;
      sidx <= '0;
      wr_valid <= 1'b0;
      wr_sect <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      load_done <= 1'b0;
      overflow <= 1'b0;
      rptr <= '0;
      wptr <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_n;
      if (rx_valid) begin
        asm_q <= asm_nx;
        bcnt <= done_word ? 3'd0 : bcnt + 3'd1;
      end
      if (done_word && state == LEN) begin
        n_q <= asm_nx[31:0];
        widx <= '0;
      end
      if (data_word) widx <= widx + 32'd1;
      if (done_word && state != RUN && sect_end && !last_sect) sidx <= sidx + SW'(1);
      if (load_wr) begin
        wr_data <= asm_nx[DW-1:0];
        wr_sect <= sidx;
        wr_addr <= base + off;
      end
      wr_valid <= wv_n;
      load_done <= state_n == RUN && !wv_n;
      overflow <= overflow || (data_word && !load_wr) || (run_word && !push);
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= asm_nx[DW-1:0];
endmodule

// File: tb/tb_io_section_loader.sv
// tb_io_section_loader: directed checks for the default loader and a 16-bit, three-section variant
module tb_io_section_loader;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, rx_data2 = 0;
  logic rx_valid = 0, rx_valid2 = 0, wr_ready = 0, wr_ready2 = 1, in_pop = 0, in_pop2 = 0;
  logic wr_valid, io_stall, load_done, in_valid, overflow;
  logic [0:0] wr_sect;
  logic [31:0] wr_addr, wr_data, in_data;
  logic [3:0] fifo_count;
  logic wr_valid2, io_stall2, load_done2, in_valid2, overflow2;
  logic [1:0] wr_sect2;
  logic [31:0] wr_addr2;
  logic [15:0] wr_data2, in_data2;
  logic [3:0] fifo_count2;
  logic [31:0] la[$], ld[$], la2[$];
  logic [15:0] ld2[$];
  logic ls[$];
  logic [1:0] ls2[$];
  int checks = 0, failures = 0, n0;

  always #5 clk = ~clk;

  io_section_loader u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sect(wr_sect), .wr_addr(wr_addr), .wr_data(wr_data),
    .io_stall(io_stall), .load_done(load_done), .in_data(in_data), .in_valid(in_valid),
    .in_pop(in_pop), .fifo_count(fifo_count), .overflow(overflow));

  io_section_loader #(.WORD_BYTES(2), .NUM_SECT(3), .SECT_BASE({32'h300, 32'h200, 32'h100})) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_sect(wr_sect2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .io_stall(io_stall2), .load_done(load_done2), .in_data(in_data2), .in_valid(in_valid2),
    .in_pop(in_pop2), .fifo_count(fifo_count2), .overflow(overflow2));

  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
      ls.push_back(wr_sect[0]);
    end
    if (!rst && wr_valid2 && wr_ready2) begin
      la2.push_back(wr_addr2);
      ld2.push_back(wr_data2);
      ls2.push_back(wr_sect2);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic sw(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sb(w[8*i +: 8]);
  endtask

  task automatic sb2(input logic [7:0] b);
    rx_data2 = b;
    rx_valid2 = 1;
    @(posedge clk); #1;
    rx_valid2 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_io_stall", io_stall, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_wr_addr", wr_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    // basic two-section load
    wr_ready = 1;
    n0 = la.size();
    sw(32'd2); sw(32'h11223344); sw(32'h55667788); sw(32'd1); sw(32'hDEADBEEF);
    @(negedge clk);
    chk("load_pending_valid", wr_valid, 1);
    chk("load_done_early", load_done, 0);
    chk("io_stall_early", io_stall, 1);
    @(negedge clk);
    chk("load_done_rise", load_done, 1);
    chk("io_stall_fall", io_stall, 0);
    chk("load_nwrites", la.size() - n0, 3);
    chk("w0_addr", la[n0], 32'h0);
    chk("w0_data", ld[n0], 32'h11223344);
    chk("w0_sect", ls[n0], 0);
    chk("w1_addr", la[n0+1], 32'h4);
    chk("w1_data", ld[n0+1], 32'h55667788);
    chk("w2_addr", la[n0+2], 32'h10000);
    chk("w2_data", ld[n0+2], 32'hDEADBEEF);
    chk("w2_sect", ls[n0+2], 1);
    // run-mode FIFO
    @(posedge clk); #1;
    for (int k = 1; k <= 8; k++) sw(32'(k));
    @(negedge clk);
    chk("fifo_full_count", fifo_count, 8);
    chk("fifo_no_ovf_yet", overflow, 0);
    @(posedge clk); #1;
    sw(32'd9);
    @(negedge clk);
    chk("fifo_drop_count", fifo_count, 8);
    chk("fifo_drop_ovf", overflow, 1);
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      in_pop = 1;
      @(negedge clk);
      chk($sformatf("pop_%0d", i), in_data, 64'(i));
      @(posedge clk); #1;
      in_pop = 0;
    end
    @(negedge clk);
    chk("fifo_empty_valid", in_valid, 0);
    chk("fifo_empty_count", fifo_count, 0);
    @(posedge clk); #1;
    in_pop = 1;
    @(posedge clk); #1;
    in_pop = 0;
    @(negedge clk);
    chk("pop_empty_count", fifo_count, 0);
    @(posedge clk); #1;
    for (int k = 10; k <= 17; k++) sw(32'(k));
    sb(8'd18); sb(8'd0); sb(8'd0);
    rx_data = 0;
    rx_valid = 1;
    in_pop = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    in_pop = 0;
    @(negedge clk);
    chk("pushpop_full_count", fifo_count, 8);
    chk("pushpop_full_head", in_data, 32'd11);
    // asynchronous reset out of run mode
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("arst_overflow", overflow, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_load_done", load_done, 0);
    chk("arst_io_stall", io_stall, 1);
    @(posedge clk); #1;
    rst = 0;
    // reset in the middle of a data word
    wr_ready = 0;
    sw(32'd2); sw(32'h0A0B0C0D); sb(8'hAA); sb(8'hBB);
    chk("midload_pending", wr_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("midload_wr_valid", wr_valid, 0);
    chk("midload_wr_data", wr_data, 0);
    chk("midload_io_stall", io_stall, 1);
    @(posedge clk); #1;
    rst = 0;
    wr_ready = 1;
    n0 = la.size();
    sw(32'd1); sw(32'h12345678); sw(32'd0);
    @(negedge clk);
    chk("fresh_nwrites", la.size() - n0, 1);
    chk("fresh_addr", la[n0], 32'h0);
    chk("fresh_data", ld[n0], 32'h12345678);
    chk("fresh_load_done", load_done, 1);
    // zero-length first section
    @(posedge clk); #1;
    do_reset();
    n0 = la.size();
    sw(32'd0); sw(32'd1); sw(32'hCAFEF00D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("zl_nwrites", la.size() - n0, 1);
    chk("zl_sect", ls[n0], 1);
    chk("zl_addr", la[n0], 32'h10000);
    chk("zl_data", ld[n0], 32'hCAFEF00D);
    // backpressure drops the second word
    @(posedge clk); #1;
    do_reset();
    wr_ready = 0;
    n0 = la.size();
    sw(32'd2); sw(32'h01020304); sw(32'h05060708);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("bp_valid", wr_valid, 1);
    chk("bp_addr", wr_addr, 32'h0);
    chk("bp_data", wr_data, 32'h01020304);
    chk("bp_ovf", overflow, 1);
    chk("bp_nwrites", la.size() - n0, 0);
    @(posedge clk); #1;
    wr_ready = 1;
    sw(32'd1); sw(32'h0F0E0D0C);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_total", la.size() - n0, 2);
    chk("bp_first", ld[n0], 32'h01020304);
    chk("bp_next_addr", la[n0+1], 32'h10000);
    // ready in the completion cycle lets the next word in
    @(posedge clk); #1;
    do_reset();
    wr_ready = 0;
    n0 = la.size();
    sw(32'd2); sw(32'h01020304);
    sb(8'h08); sb(8'h07); sb(8'h06);
    rx_data = 8'h05;
    rx_valid = 1;
    wr_ready = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    wr_ready = 0;
    @(negedge clk);
    chk("b2b_data", wr_data, 32'h05060708);
    chk("b2b_addr", wr_addr, 32'h4);
    chk("b2b_valid", wr_valid, 1);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_first", ld[n0], 32'h01020304);
    // 16-bit words, three sections
    @(posedge clk); #1;
    do_reset();
    n0 = la2.size();
    sb2(8'h01); sb2(8'h00); sb2(8'h00); sb2(8'h00); sb2(8'hBB); sb2(8'hAA);
    sb2(8'h01); sb2(8'h00); sb2(8'h00); sb2(8'h00); sb2(8'hDD); sb2(8'hCC);
    sb2(8'h01); sb2(8'h00); sb2(8'h00); sb2(8'h00); sb2(8'hFF); sb2(8'hEE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("w16_nwrites", la2.size() - n0, 3);
    chk("w16_a0", la2[n0], 32'h100);
    chk("w16_d0", ld2[n0], 16'hAABB);
    chk("w16_a1", la2[n0+1], 32'h200);
    chk("w16_d1", ld2[n0+1], 16'hCCDD);
    chk("w16_a2", la2[n0+2], 32'h300);
    chk("w16_d2", ld2[n0+2], 16'hEEFF);
    chk("w16_s2", ls2[n0+2], 2);
    chk("w16_done", load_done2, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
